// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus CPU datapath: word size, register count,
// ALU opcode encodings and a rotate helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package datapath_pkg;

   localparam int WORD    = 32;
   localparam int NUM_GPR = 16;

   // ALU operation encodings (5-bit opcode field)
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   // Rotate right by n in 0..32. Shifting the doubled word makes n=0 and n=32
   // both return the word unchanged, so rol can reuse this with n = 32 - amt.
   function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] v, input logic [5:0] n);
      return WORD'({v, v} >> n);
   endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A (from Y) and B (from bus) -> 64-bit result for Z.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: a_i, b_i (32b operands), opcode_i (5b op select), inc_pc_i (forces B+1),
//        result_o (64b; upper half is 0 except for mul/div).
module datapath_alu
   import datapath_pkg::*;
(
   input  logic [WORD-1:0]   a_i,
   input  logic [WORD-1:0]   b_i,
   input  logic [4:0]        opcode_i,
   input  logic              inc_pc_i,
   output logic [2*WORD-1:0] result_o
);

   logic signed [WORD-1:0]   sa;
   logic signed [WORD-1:0]   sb;
   logic signed [2*WORD-1:0] sa_ext;
   logic signed [2*WORD-1:0] sb_ext;
   logic signed [2*WORD-1:0] prod;
   logic [WORD-1:0]          quot;
   logic [WORD-1:0]          rem;
   logic [4:0]               amt;

   always_comb begin
      sa     = $signed(a_i);
      sb     = $signed(b_i);
      sa_ext = $signed({{WORD{a_i[WORD-1]}}, a_i});
      sb_ext = $signed({{WORD{b_i[WORD-1]}}, b_i});
      prod   = sa_ext * sb_ext;
      amt    = b_i[4:0];

      // Divide by zero and the single overflowing case (-2^31 / -1) are
      // pinned down explicitly so the result never depends on the tool.
      quot = '0;
      rem  = '0;
      if (b_i == '0) begin
         quot = '1;
         rem  = a_i;
      end else if ((a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
         quot = 32'h8000_0000;
         rem  = '0;
      end else begin
         quot = WORD'(sa / sb);
         rem  = WORD'(sa % sb);
      end

      result_o = '0;
      if (inc_pc_i) begin
         result_o = {{WORD{1'b0}}, b_i + 32'd1};
      end else begin
         case (opcode_i)
            OP_ADD:  result_o = {{WORD{1'b0}}, a_i + b_i};
            OP_SUB:  result_o = {{WORD{1'b0}}, a_i - b_i};
            OP_AND:  result_o = {{WORD{1'b0}}, a_i & b_i};
            OP_OR:   result_o = {{WORD{1'b0}}, a_i | b_i};
            OP_SHR:  result_o = {{WORD{1'b0}}, a_i >> amt};
            OP_SHRA: result_o = {{WORD{1'b0}}, WORD'(sa >>> amt)};
            OP_SHL:  result_o = {{WORD{1'b0}}, a_i << amt};
            OP_ROR:  result_o = {{WORD{1'b0}}, rotr(a_i, {1'b0, amt})};
            OP_ROL:  result_o = {{WORD{1'b0}}, rotr(a_i, 6'd32 - {1'b0, amt})};
            OP_MUL:  result_o = prod;
            OP_DIV:  result_o = {rem, quot};
            OP_NEG:  result_o = {{WORD{1'b0}}, 32'd0 - b_i};
            OP_NOT:  result_o = {{WORD{1'b0}}, ~b_i};
            default: result_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: R0-R15, PC, MAR, MDR, HI, LO, Y, 64-bit Z and ALU.
// Latency: register loads take effect on the next rising clock; bus and ALU are combinational.
// Backpressure: none; every strobe is obeyed in the cycle it is presented.
// Ports: clock/clear (async active-low); Mdatain+Read feed MDR; Rin/Rout per-GPR strobes;
//        *in load enables, *out bus drives; Cout drives 0; opcode/IncPC steer the ALU;
//        bus_o (shared bus), mar_o (memory address), mdr_o (memory write data) observe state.
module datapath
   import datapath_pkg::*;
(
   input  logic               clock,
   input  logic               clear,
   input  logic [WORD-1:0]    Mdatain,
   input  logic               Read,
   input  logic               IncPC,
   input  logic [NUM_GPR-1:0] Rin,
   input  logic [NUM_GPR-1:0] Rout,
   input  logic               PCin,
   input  logic               Zin,
   input  logic               MDRin,
   input  logic               MARin,
   input  logic               Yin,
   input  logic               HIin,
   input  logic               LOin,
   input  logic               PCout,
   input  logic               Zhighout,
   input  logic               Zlowout,
   input  logic               HIout,
   input  logic               LOout,
   input  logic               MDRout,
   input  logic               Cout,
   input  logic [4:0]         opcode,
   output logic [WORD-1:0]    bus_o,
   output logic [WORD-1:0]    mar_o,
   output logic [WORD-1:0]    mdr_o
);

   logic [WORD-1:0]   gpr_q [NUM_GPR];
   logic [WORD-1:0]   pc_q;
   logic [WORD-1:0]   mar_q;
   logic [WORD-1:0]   mdr_q;
   logic [WORD-1:0]   hi_q;
   logic [WORD-1:0]   lo_q;
   logic [WORD-1:0]   y_q;
   logic [2*WORD-1:0] z_q;

   logic [WORD-1:0]   bus;
   logic [WORD-1:0]   mdr_d;
   logic [2*WORD-1:0] z_d;

   // Bus mux. Sources are applied from lowest to highest priority so the
   // last matching assignment wins: Cout lowest, R0 highest.
   always_comb begin
      bus = '0;
      if (Cout)     bus = '0;
      if (MDRout)   bus = mdr_q;
      if (LOout)    bus = lo_q;
      if (HIout)    bus = hi_q;
      if (Zlowout)  bus = z_q[WORD-1:0];
      if (Zhighout) bus = z_q[2*WORD-1:WORD];
      if (PCout)    bus = pc_q;
      for (int i = NUM_GPR-1; i >= 0; i--) begin
         if (Rout[i]) bus = gpr_q[i];
      end
   end

   assign mdr_d = Read ? Mdatain : bus;

   datapath_alu u_alu (
      .a_i      (y_q),
      .b_i      (bus),
      .opcode_i (opcode),
      .inc_pc_i (IncPC),
      .result_o (z_d)
   );

   // General-purpose registers
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_GPR; i++) begin
            if (Rin[i]) gpr_q[i] <= bus;
         end
      end
   end

   // Special registers. A register that is both driving and loading the bus
   // simply recaptures its own value.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         pc_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         y_q   <= '0;
         z_q   <= '0;
      end else begin
         if (PCin)  pc_q  <= bus;
         if (MARin) mar_q <= bus;
         if (MDRin) mdr_q <= mdr_d;
         if (HIin)  hi_q  <= bus;
         if (LOin)  lo_q  <= bus;
         if (Yin)   y_q   <= bus;
         if (Zin)   z_q   <= z_d;
      end
   end

   assign bus_o = bus;
   assign mar_o = mar_q;
   assign mdr_o = mdr_q;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the single-bus datapath.
module tb_datapath;
   import datapath_pkg::*;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] Mdatain;
   logic        Read, IncPC;
   logic [15:0] Rin, Rout;
   logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin;
   logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
   logic [4:0]  opcode;
   logic [31:0] bus_o, mar_o, mdr_o;

   int n_checks = 0;
   int n_errors = 0;

   datapath dut (
      .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
      .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
      .Yin(Yin), .HIin(HIin), .LOin(LOin), .PCout(PCout), .Zhighout(Zhighout),
      .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout), .Cout(Cout),
      .opcode(opcode), .bus_o(bus_o), .mar_o(mar_o), .mdr_o(mdr_o)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      Read = 0; IncPC = 0; Rin = '0; Rout = '0;
      PCin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
      PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0; LOout = 0; MDRout = 0; Cout = 0;
      opcode = '0;
   endtask

   // Let the current strobes take effect on the next edge, then drop them.
   task automatic tick();
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic load_mdr(input logic [31:0] v);
      Mdatain = v; Read = 1; MDRin = 1;
      tick();
   endtask

   task automatic set_gpr(input int i, input logic [31:0] v);
      load_mdr(v);
      MDRout = 1; Rin[i] = 1;
      tick();
   endtask

   task automatic set_y(input logic [31:0] v);
      load_mdr(v);
      MDRout = 1; Yin = 1;
      tick();
   endtask

   task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
      set_y(a);
      load_mdr(b);
      MDRout = 1; opcode = op; Zin = 1;
      tick();
   endtask

   task automatic check_gpr(input string tag, input int i, input logic [31:0] exp);
      Rout[i] = 1; #1;
      check(tag, {32'h0, bus_o}, {32'h0, exp});
      idle();
   endtask

   task automatic check_z(input string tag, input logic [63:0] exp);
      logic [63:0] got;
      Zlowout = 1; #1; got[31:0] = bus_o; idle();
      Zhighout = 1; #1; got[63:32] = bus_o; idle();
      check(tag, got, exp);
   endtask

   typedef struct {
      string       tag;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  op;
      logic [63:0] exp;
   } alu_vec_t;

   alu_vec_t vecs[$];

   initial begin
      vecs = '{
         '{"mul -2*3",   32'hFFFF_FFFE, 32'd3, OP_MUL,  64'hFFFF_FFFF_FFFF_FFFA},
         '{"div -7/2",   32'hFFFF_FFF9, 32'd2, OP_DIV,  64'hFFFF_FFFF_FFFF_FFFD},
         '{"shra",       32'h8000_0001, 32'd1, OP_SHRA, 64'h0000_0000_C000_0000},
         '{"ror",        32'h8000_0001, 32'd1, OP_ROR,  64'h0000_0000_C000_0000},
         '{"shr",        32'h8000_0001, 32'd1, OP_SHR,  64'h0000_0000_4000_0000},
         '{"shl",        32'h8000_0001, 32'd1, OP_SHL,  64'h0000_0000_0000_0002},
         '{"rol",        32'h8000_0001, 32'd1, OP_ROL,  64'h0000_0000_0000_0003},
         '{"ror by 32",  32'h1234_5678, 32'd32, OP_ROR, 64'h0000_0000_1234_5678},
         '{"add wrap",   32'hFFFF_FFFF, 32'd2, OP_ADD,  64'h0000_0000_0000_0001},
         '{"sub",        32'd3,         32'd5, OP_SUB,  64'h0000_0000_FFFF_FFFE},
         '{"and",        32'hF0F0_00FF, 32'h0FF0_0F0F, OP_AND, 64'h0000_0000_00F0_000F},
         '{"or",         32'hF0F0_00FF, 32'h0FF0_0F0F, OP_OR,  64'h0000_0000_FFF0_0FFF},
         '{"neg",        32'd9,         32'd1, OP_NEG,  64'h0000_0000_FFFF_FFFF},
         '{"not",        32'd9,         32'd1, OP_NOT,  64'h0000_0000_FFFF_FFFE},
         '{"mul big",    32'h7FFF_FFFF, 32'h7FFF_FFFF, OP_MUL, 64'h3FFF_FFFF_0000_0001},
         '{"bad opcode", 32'd9,         32'd1, 5'b01100, 64'h0}
      };

      idle();
      Mdatain = '0;
      clear = 0;
      #12;
      clear = 1;

      // Reset state
      check_gpr("reset R0", 0, 32'h0);
      check_gpr("reset R15", 15, 32'h0);
      PCout = 1; #1; check("reset PC", {32'h0, bus_o}, 64'h0); idle();
      check_z("reset Z", 64'h0);
      check("reset MAR", {32'h0, mar_o}, 64'h0);
      check("reset MDR", {32'h0, mdr_o}, 64'h0);

      // Rotate-left program: R6=0x18, R4=0x14, R6 <- R6 rol R4
      load_mdr(32'h18);
      check("MDR from Mdatain", {32'h0, mdr_o}, 64'h18);
      MDRout = 1; Rin[6] = 1; #1;
      check("bus from MDR", {32'h0, bus_o}, 64'h18);
      tick();
      set_gpr(4, 32'h14);
      Rout[6] = 1; Yin = 1; tick();
      Rout[4] = 1; opcode = OP_ROL; Zin = 1; tick();
      Zlowout = 1; Rin[6] = 1; tick();
      check_gpr("R6 rol result", 6, 32'h0180_0000);
      check_gpr("R4 kept", 4, 32'h14);

      // Fetch step: PC=5 -> MAR=5, Z=6, PC=6
      load_mdr(32'd5);
      MDRout = 1; PCin = 1; tick();
      PCout = 1; MARin = 1; IncPC = 1; opcode = OP_MUL; Zin = 1; #1;
      check("bus from PC", {32'h0, bus_o}, 64'd5);
      tick();
      check("MAR from PC", {32'h0, mar_o}, 64'd5);
      check_z("IncPC Z", 64'd6);
      Zlowout = 1; PCin = 1; tick();
      PCout = 1; #1; check("PC incremented", {32'h0, bus_o}, 64'd6); idle();

      // ALU vectors
      foreach (vecs[i]) begin
         alu_run(vecs[i].a, vecs[i].b, vecs[i].op);
         check_z(vecs[i].tag, vecs[i].exp);
      end

      // Divide by zero, bus driven to 0 by Cout
      set_y(32'hFFFF_FFF9);
      Cout = 1; opcode = OP_DIV; Zin = 1; tick();
      check_z("div by zero", 64'hFFFF_FFF9_FFFF_FFFF);

      // HI/LO load from bus
      Zhighout = 1; HIin = 1; tick();
      Zlowout = 1; LOin = 1; tick();
      HIout = 1; #1; check("HI load", {32'h0, bus_o}, 64'hFFFF_FFF9); idle();
      LOout = 1; #1; check("LO load", {32'h0, bus_o}, 64'hFFFF_FFFF); idle();

      // Bus priority: lowest GPR wins, GPR beats PC, PC beats MDR
      set_gpr(9, 32'hAAAA_0009);
      Rout[9] = 1; Rout[4] = 1; PCout = 1; MDRout = 1; #1;
      check("prio R4 over R9", {32'h0, bus_o}, 64'h14); idle();
      PCout = 1; MDRout = 1; HIout = 1; #1;
      check("prio PC over HI/MDR", {32'h0, bus_o}, 64'd6); idle();
      LOout = 1; MDRout = 1; Cout = 1; #1;
      check("prio LO over MDR", {32'h0, bus_o}, 64'hFFFF_FFFF); idle();

      // Same register driving and loading keeps its value
      Rout[9] = 1; Rin[9] = 1; tick();
      check_gpr("R9 self reload", 9, 32'hAAAA_0009);

      // Asynchronous clear between edges, including across a pending load
      load_mdr(32'hAB);
      #2;
      Mdatain = 32'h55; Read = 1; MDRin = 1; Rout[6] = 1;
      clear = 0; #1;
      check("clear R6 async", {32'h0, bus_o}, 64'h0);
      check("clear MAR async", {32'h0, mar_o}, 64'h0);
      check("clear MDR async", {32'h0, mdr_o}, 64'h0);
      @(posedge clock); #1;
      check("clear beats load", {32'h0, mdr_o}, 64'h0);
      idle();
      clear = 1;
      check_gpr("R9 after clear", 9, 32'h0);
      check_z("Z after clear", 64'h0);
      #1; check("no strobes bus", {32'h0, bus_o}, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
